// File: rtl/rv_pkg.sv
// Types and constants shared by both ends of the 64-bit ready/valid link.
package rv_pkg;

    localparam int RV_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FULL
    } rv_tx_state_t;

endpackage

// File: rtl/rv_transmitter_if.sv
// Push side and link side of the transmitter bundled together.
// The master modport is the transmitter's view; slave is the producer/receiver view.
interface rv_transmitter_if
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = RV_DATA_WIDTH
);

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_ready;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;

    modport master (
        input  push,
        input  push_data,
        input  ready,
        output push_ready,
        output valid,
        output data_out
    );

    modport slave (
        output push,
        output push_data,
        output ready,
        input  push_ready,
        input  valid,
        input  data_out
    );

endinterface

// File: rtl/reg_def.sv
// Plain D register with asynchronous active-high clear.
module reg_def #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/rv_tx_fifo.sv
// Small circular FIFO for the transmitter: storage, wrapping pointers, occupancy count.
module rv_tx_fifo
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = RV_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv_transmitter.sv
// Source end of the 64-bit ready/valid link: FIFO-buffered push side, FSM-driven valid.
// Optional RV_TX_STALL_CNT_EN adds a saturating stall_cycles counter output.
module rv_transmitter
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = RV_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    rv_transmitter_if.master bus,
    output logic             tx_done,
    output logic             overflow,
    output logic [CNT_W-1:0] count
`ifdef RV_TX_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE_OFF = CNT_W'(DEPTH - 1);

    rv_tx_state_t          state;
    logic                  valid_r;
    logic                  push_ready_r;
    logic                  handshake;
    logic                  push_acc;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head;

    // valid comes only from registered state, never from ready.
    assign handshake      = valid_r && bus.ready;
    assign push_acc       = bus.push && !fifo_full;
    assign bus.valid      = valid_r;
    assign bus.push_ready = push_ready_r;
    assign bus.data_out   = fifo_empty ? '0 : head;

    rv_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_acc),
        .rd_en   (handshake),
        .wr_data (bus.push_data),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            valid_r      <= 1'b0;
            push_ready_r <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            if (bus.push && fifo_full) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (push_acc) begin
                        state   <= SEND;
                        valid_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake && !push_acc && count == CNT_ONE) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                    end else if (push_acc && !handshake && count == CNT_ONE_OFF) begin
                        state        <= FULL;
                        push_ready_r <= 1'b0;
                    end
                end
                FULL: begin
                    if (handshake) begin
                        state        <= SEND;
                        push_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    valid_r      <= 1'b0;
                    push_ready_r <= 1'b1;
                end
            endcase
        end
    end

    reg_def #(
        .WIDTH (1)
    ) u_tx_done (
        .clk   (clk),
        .reset (reset),
        .d     (handshake),
        .q     (tx_done)
    );

`ifdef RV_TX_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (handshake) begin
            stall_cycles <= '0;
        end else if (valid_r && !bus.ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_transmitter.sv
// Randomised and directed bench for rv_transmitter against a queue-based link model.
module tb_rv_transmitter;
    import rv_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             tx_done;
    logic             overflow;
    logic [CNT_W-1:0] count;
`ifdef RV_TX_STALL_CNT_EN
    logic [15:0]      stall_cycles;
`endif

    rv_transmitter_if #(.DATA_WIDTH(DW)) bus ();

    rv_transmitter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_done  (tx_done),
        .overflow (overflow),
        .count    (count)
`ifdef RV_TX_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: the FIFO contents as a queue plus the observable flags.
    logic [63:0] mq[$];
    bit          m_ovf;
    bit          m_txd;
    int unsigned m_stall;
    logic [63:0] popped[$];
    int unsigned txd_run;
    int unsigned txd_run_max;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_txd   = 1'b0;
        m_stall = 0;
    endtask

    task automatic check_outputs();
        check("valid",      bus.valid,      mq.size() != 0);
        check("data_out",   bus.data_out,   (mq.size() != 0) ? mq[0] : 64'h0);
        check("push_ready", bus.push_ready, mq.size() < DEPTH);
        check("count",      count,          mq.size());
        check("overflow",   overflow,       m_ovf);
        check("tx_done",    tx_done,        m_txd);
`ifdef RV_TX_STALL_CNT_EN
        check("stall",      stall_cycles,   m_stall);
`endif
    endtask

    // Called at posedge+1; drives one cycle, checks, advances model, returns at posedge+1.
    task automatic cycle(input bit p, input logic [63:0] d, input bit r);
        bit hs, acc, vb;
        bus.push      = p;
        bus.push_data = d;
        bus.ready     = r;
        #1;
        check_outputs();
        vb  = (mq.size() != 0);
        hs  = vb && r;
        acc = p && (mq.size() < DEPTH);
        if (hs) popped.push_back(bus.data_out);
        @(posedge clk);
        if (hs) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        if (p && !acc) m_ovf = 1'b1;
        m_txd = hs;
        if (hs) m_stall = 0;
        else if (vb && !r && m_stall < 65535) m_stall++;
        #1;
        if (tx_done) begin
            txd_run++;
            if (txd_run > txd_run_max) txd_run_max = txd_run;
        end else begin
            txd_run = 0;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.ready     = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word: latency, handshake, tx_done pulse, back to empty.
        cycle(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        check("t1_valid", bus.valid, 1'b1);
        check("t1_data",  bus.data_out, 64'hDEAD_BEEF_0000_0001);
        cycle(1'b0, '0, 1'b1);
        check("t1_txd",   tx_done, 1'b1);
        check("t1_count", count, 0);
        check("t1_idle",  bus.valid, 1'b0);
        cycle(1'b0, '0, 1'b0);

        // Fill while stalled, hold, then overflow.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'h10 + 64'(i), 1'b0);
        check("t2_count", count, 4);
        check("t2_pr",    bus.push_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0);
            check("t2_hold", bus.data_out, 64'h10);
        end
        cycle(1'b1, 64'h77, 1'b0);
        check("t2_ovf",   overflow, 1'b1);
        check("t2_count4", count, 4);

        // Full: pop and push in one cycle, push refused.
        cycle(1'b1, 64'h99, 1'b1);
        check("t3_count", count, 3);
        check("t3_data",  bus.data_out, 64'h11);
        check("t3_ovf",   overflow, 1'b1);

        // Simultaneous push/pop at count 2.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 64'hA0, 1'b1);
        check("t4_count", count, 2);
        check("t4_order", bus.data_out, 64'h13);
        cycle(1'b0, '0, 1'b1);
        check("t4_next",  bus.data_out, 64'hA0);
        cycle(1'b0, '0, 1'b1);
        check("t4_empty", count, 0);

        // Continuous stream of 12 words through the wrapping pointers.
        popped.delete();
        txd_run_max = 0;
        for (int i = 0; i < 12; i++) cycle(1'b1, 64'(i), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("t4_npop", popped.size(), 12);
        for (int i = 0; i < 12 && i < popped.size(); i++) check("t4_seq", popped[i], 64'(i));
        check("t4_txrun", txd_run_max, 12);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0);

        // Reset asserted mid-transfer with the FIFO full.
        for (int i = 0; i < 6; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0);
        check("t5_full", count, 4);
        check("t5_vld",  bus.valid, 1'b1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_rvalid", bus.valid, 1'b0);
        check("t5_rcount", count, 0);
        check("t5_rovf",   overflow, 1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        popped.delete();
        cycle(1'b1, 64'h55, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check("t5_npop", popped.size(), 1);
        if (popped.size() > 0) check("t5_word", popped[0], 64'h55);

`ifdef RV_TX_STALL_CNT_EN
        cycle(1'b1, 64'hC0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0);
        check("t6_stall7", stall_cycles, 16'd7);
        cycle(1'b0, '0, 1'b1);
        check("t6_stall0", stall_cycles, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
